// File: rtl/riscv_inst_encoder_pkg.sv
// Shared RV32I encoding definitions: op indices, opcode/funct fields, NOP word, formats.
package riscv_inst_encoder_pkg;

  // Operation indices, in decoder order.
  localparam logic [5:0] OpAdd   = 6'd0;
  localparam logic [5:0] OpSub   = 6'd1;
  localparam logic [5:0] OpXor   = 6'd2;
  localparam logic [5:0] OpOr    = 6'd3;
  localparam logic [5:0] OpAnd   = 6'd4;
  localparam logic [5:0] OpSll   = 6'd5;
  localparam logic [5:0] OpSrl   = 6'd6;
  localparam logic [5:0] OpSra   = 6'd7;
  localparam logic [5:0] OpSlt   = 6'd8;
  localparam logic [5:0] OpSltu  = 6'd9;
  localparam logic [5:0] OpAddi  = 6'd10;
  localparam logic [5:0] OpXori  = 6'd11;
  localparam logic [5:0] OpOri   = 6'd12;
  localparam logic [5:0] OpAndi  = 6'd13;
  localparam logic [5:0] OpSlli  = 6'd14;
  localparam logic [5:0] OpSrli  = 6'd15;
  localparam logic [5:0] OpSrai  = 6'd16;
  localparam logic [5:0] OpSlti  = 6'd17;
  localparam logic [5:0] OpSltiu = 6'd18;
  localparam logic [5:0] OpLb    = 6'd19;
  localparam logic [5:0] OpLh    = 6'd20;
  localparam logic [5:0] OpLw    = 6'd21;
  localparam logic [5:0] OpLbu   = 6'd22;
  localparam logic [5:0] OpLhu   = 6'd23;
  localparam logic [5:0] OpSb    = 6'd24;
  localparam logic [5:0] OpSh    = 6'd25;
  localparam logic [5:0] OpSw    = 6'd26;
  localparam logic [5:0] OpBeq   = 6'd27;
  localparam logic [5:0] OpBne   = 6'd28;
  localparam logic [5:0] OpBlt   = 6'd29;
  localparam logic [5:0] OpBge   = 6'd30;
  localparam logic [5:0] OpBltu  = 6'd31;
  localparam logic [5:0] OpBgeu  = 6'd32;
  localparam logic [5:0] OpJal   = 6'd33;
  localparam logic [5:0] OpJalr  = 6'd34;
  localparam logic [5:0] OpLui   = 6'd35;
  localparam logic [5:0] OpAuipc = 6'd36;
  localparam logic [5:0] OpLast  = OpAuipc;

  // Major opcodes.
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  // funct3 values (ALU, load, store, branch share some encodings).
  localparam logic [2:0] F3Add  = 3'd0;
  localparam logic [2:0] F3Sll  = 3'd1;
  localparam logic [2:0] F3Slt  = 3'd2;
  localparam logic [2:0] F3Sltu = 3'd3;
  localparam logic [2:0] F3Xor  = 3'd4;
  localparam logic [2:0] F3Srl  = 3'd5;
  localparam logic [2:0] F3Or   = 3'd6;
  localparam logic [2:0] F3And  = 3'd7;
  localparam logic [2:0] F3B    = 3'd0;
  localparam logic [2:0] F3H    = 3'd1;
  localparam logic [2:0] F3W    = 3'd2;
  localparam logic [2:0] F3Bu   = 3'd4;
  localparam logic [2:0] F3Hu   = 3'd5;
  localparam logic [2:0] F3Beq  = 3'd0;
  localparam logic [2:0] F3Bne  = 3'd1;
  localparam logic [2:0] F3Blt  = 3'd4;
  localparam logic [2:0] F3Bge  = 3'd5;
  localparam logic [2:0] F3Bltu = 3'd6;
  localparam logic [2:0] F3Bgeu = 3'd7;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  // ADDI x0, x0, 0
  localparam logic [31:0] NopWord = 32'h0000_0013;

  typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtJ, FmtU} fmt_e;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_info_t;

  // Static per-op encoding fields; unknown ops fall back to the NOP fields.
  function automatic op_info_t op_info(input logic [5:0] op);
    op_info_t info;
    info = '{FmtI, OpcOpImm, F3Add, F7Base};
    case (op)
      OpAdd:   info = '{FmtR,  OpcOp,     F3Add,  F7Base};
      OpSub:   info = '{FmtR,  OpcOp,     F3Add,  F7Alt};
      OpXor:   info = '{FmtR,  OpcOp,     F3Xor,  F7Base};
      OpOr:    info = '{FmtR,  OpcOp,     F3Or,   F7Base};
      OpAnd:   info = '{FmtR,  OpcOp,     F3And,  F7Base};
      OpSll:   info = '{FmtR,  OpcOp,     F3Sll,  F7Base};
      OpSrl:   info = '{FmtR,  OpcOp,     F3Srl,  F7Base};
      OpSra:   info = '{FmtR,  OpcOp,     F3Srl,  F7Alt};
      OpSlt:   info = '{FmtR,  OpcOp,     F3Slt,  F7Base};
      OpSltu:  info = '{FmtR,  OpcOp,     F3Sltu, F7Base};
      OpAddi:  info = '{FmtI,  OpcOpImm,  F3Add,  F7Base};
      OpXori:  info = '{FmtI,  OpcOpImm,  F3Xor,  F7Base};
      OpOri:   info = '{FmtI,  OpcOpImm,  F3Or,   F7Base};
      OpAndi:  info = '{FmtI,  OpcOpImm,  F3And,  F7Base};
      OpSlli:  info = '{FmtSh, OpcOpImm,  F3Sll,  F7Base};
      OpSrli:  info = '{FmtSh, OpcOpImm,  F3Srl,  F7Base};
      OpSrai:  info = '{FmtSh, OpcOpImm,  F3Srl,  F7Alt};
      OpSlti:  info = '{FmtI,  OpcOpImm,  F3Slt,  F7Base};
      OpSltiu: info = '{FmtI,  OpcOpImm,  F3Sltu, F7Base};
      OpLb:    info = '{FmtI,  OpcLoad,   F3B,    F7Base};
      OpLh:    info = '{FmtI,  OpcLoad,   F3H,    F7Base};
      OpLw:    info = '{FmtI,  OpcLoad,   F3W,    F7Base};
      OpLbu:   info = '{FmtI,  OpcLoad,   F3Bu,   F7Base};
      OpLhu:   info = '{FmtI,  OpcLoad,   F3Hu,   F7Base};
      OpSb:    info = '{FmtS,  OpcStore,  F3B,    F7Base};
      OpSh:    info = '{FmtS,  OpcStore,  F3H,    F7Base};
      OpSw:    info = '{FmtS,  OpcStore,  F3W,    F7Base};
      OpBeq:   info = '{FmtB,  OpcBranch, F3Beq,  F7Base};
      OpBne:   info = '{FmtB,  OpcBranch, F3Bne,  F7Base};
      OpBlt:   info = '{FmtB,  OpcBranch, F3Blt,  F7Base};
      OpBge:   info = '{FmtB,  OpcBranch, F3Bge,  F7Base};
      OpBltu:  info = '{FmtB,  OpcBranch, F3Bltu, F7Base};
      OpBgeu:  info = '{FmtB,  OpcBranch, F3Bgeu, F7Base};
      OpJal:   info = '{FmtJ,  OpcJal,    F3Add,  F7Base};
      OpJalr:  info = '{FmtI,  OpcJalr,   F3Add,  F7Base};
      OpLui:   info = '{FmtU,  OpcLui,    F3Add,  F7Base};
      OpAuipc: info = '{FmtU,  OpcAuipc,  F3Add,  F7Base};
      default: info = '{FmtI,  OpcOpImm,  F3Add,  F7Base};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/riscv_inst_encoder_imm_pack.sv
// Scatters an immediate into its bit positions for a given instruction format.
module riscv_imm_pack
  import riscv_inst_encoder_pkg::*;
(
  input  fmt_e        i_fmt,
  input  logic [31:0] i_imm,
  output logic [31:0] o_bits
);

  // Immediate bits only; every non-immediate field is left zero.
  always_comb begin
    o_bits = '0;
    case (i_fmt)
      FmtI:    o_bits = {i_imm[11:0], 20'b0};
      FmtSh:   o_bits = {7'b0, i_imm[4:0], 20'b0};
      FmtS:    o_bits = {i_imm[11:5], 13'b0, i_imm[4:0], 7'b0};
      FmtB:    o_bits = {i_imm[12], i_imm[10:5], 13'b0, i_imm[4:1], i_imm[11], 7'b0};
      FmtJ:    o_bits = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], 12'b0};
      FmtU:    o_bits = {i_imm[31:12], 12'b0};
      default: o_bits = '0;
    endcase
  end

endmodule

// File: rtl/riscv_inst_encoder.sv
// Two-stage RV32I encoder: stage 1 decodes/range-checks, stage 2 assembles the word.
module riscv_inst_encoder
  import riscv_inst_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [ERR_W-1:0] err_count
);

  logic               w_s2_free, w_s1_adv, w_accept, w_xfer;
  op_info_t           w_info;
  logic               w_err;
  logic signed [31:0] w_imm_s;
  logic [31:0]        w_imm_bits, w_word;

  logic               r_s1_valid, r_s1_err;
  op_info_t           r_s1_info;
  logic [4:0]         r_s1_rd, r_s1_rs1, r_s1_rs2;
  logic [31:0]        r_s1_imm;

  logic               r_s2_valid, r_s2_err;
  logic [31:0]        r_s2_inst;

  logic [CNT_W-1:0]   r_enc_cnt;
  logic [ERR_W-1:0]   r_err_cnt;

  // Stage 2 can take a new word if empty or its word leaves this cycle.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = r_s2_valid && out_ready;
  assign w_imm_s   = $signed(in_imm);

  // Decode the incoming op and flag operands that cannot be encoded.
  always_comb begin
    w_info = op_info(in_op);
    w_err  = 1'b0;
    if (in_op > OpLast) begin
      w_err = 1'b1;
    end else begin
      case (w_info.fmt)
        FmtI, FmtS: w_err = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
        FmtSh:      w_err = |in_imm[31:5];
        FmtB:       w_err = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || in_imm[0];
        FmtJ:       w_err = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) || in_imm[0];
        FmtU:       w_err = |in_imm[11:0];
        default:    w_err = 1'b0;
      endcase
    end
  end

  // Stage 1 register: holds the decoded bundle until stage 2 takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_info  <= '0;
      r_s1_rd    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
      r_s1_imm   <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= w_err;
      r_s1_info  <= w_info;
      r_s1_rd    <= in_rd;
      r_s1_rs1   <= in_rs1;
      r_s1_rs2   <= in_rs2;
      r_s1_imm   <= in_imm;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  riscv_imm_pack u_imm_pack (
    .i_fmt  (r_s1_info.fmt),
    .i_imm  (r_s1_imm),
    .o_bits (w_imm_bits)
  );

  // Assemble the word: only fields the format owns are filled in.
  always_comb begin
    w_word      = w_imm_bits;
    w_word[6:0] = r_s1_info.opcode;
    case (r_s1_info.fmt)
      FmtR, FmtSh: begin
        w_word[11:7]  = r_s1_rd;
        w_word[14:12] = r_s1_info.funct3;
        w_word[19:15] = r_s1_rs1;
        w_word[31:25] = r_s1_info.funct7;
        if (r_s1_info.fmt == FmtR) w_word[24:20] = r_s1_rs2;
      end
      FmtI: begin
        w_word[11:7]  = r_s1_rd;
        w_word[14:12] = r_s1_info.funct3;
        w_word[19:15] = r_s1_rs1;
      end
      FmtS, FmtB: begin
        w_word[14:12] = r_s1_info.funct3;
        w_word[19:15] = r_s1_rs1;
        w_word[24:20] = r_s1_rs2;
      end
      FmtJ, FmtU: w_word[11:7] = r_s1_rd;
      default: ;
    endcase
    if (r_s1_err) w_word = NopWord;
  end

  // Stage 2 / output register: only reloads when free, so a stalled word stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_inst  <= NopWord;
      r_s2_err   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_inst  <= w_word;
      r_s2_err   <= r_s1_err;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // Transfer counters: total wraps, error count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else if (w_xfer) begin
      r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      if (r_s2_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_inst  = r_s2_inst;
  assign out_err   = r_s2_err;
  assign enc_count = r_enc_cnt;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_riscv_inst_encoder.sv
// Randomized bench for riscv_inst_encoder against an arithmetic RV32I encoding model.
module tb_riscv_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  riscv_inst_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  localparam int F3R[10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
  localparam int F3I[9]  = '{0, 4, 6, 7, 1, 5, 5, 2, 3};
  localparam int F3L[5]  = '{0, 1, 2, 4, 5};
  localparam int F3BR[6] = '{0, 1, 4, 5, 6, 7};
  localparam int BND[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                             -4098, 1048574, 1048576, -1048576, -1048578, 31, 32, 0};

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  int   m_enc = 0;
  int   m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Encoding straight from the ISA field layout, using integer arithmetic per op range.
  function automatic exp_t ref_enc(input logic [5:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] imm);
    exp_t        e;
    int          o, s;
    logic [31:0] d, a, b, w, f3, opc;
    bit          bad;
    o = int'({26'b0, op});
    s = int'(imm);
    d = {27'b0, rd} << 7;
    a = {27'b0, rs1} << 15;
    b = {27'b0, rs2} << 20;
    bad = 1'b0;
    w = 32'h13;
    if (o <= 9) begin
      f3 = 32'(F3R[o]);
      w = ((o == 1 || o == 7) ? 32'h4000_0000 : 32'h0) | b | a | (f3 << 12) | d | 32'h33;
    end else if (o >= 14 && o <= 16) begin
      bad = imm > 32'd31;
      f3 = (o == 14) ? 32'd1 : 32'd5;
      w = ((o == 16) ? 32'h4000_0000 : 32'h0) | (imm << 20) | a | (f3 << 12) | d | 32'h13;
    end else if (o <= 23 || o == 34) begin
      bad = (s < -2048) || (s > 2047);
      if (o <= 18)      begin f3 = 32'(F3I[o - 10]); opc = 32'h13; end
      else if (o <= 23) begin f3 = 32'(F3L[o - 19]); opc = 32'h03; end
      else              begin f3 = 32'd0;            opc = 32'h67; end
      w = ((imm & 32'hfff) << 20) | a | (f3 << 12) | d | opc;
    end else if (o <= 26) begin
      bad = (s < -2048) || (s > 2047);
      f3 = 32'(o - 24);
      w = (((imm >> 5) & 32'h7f) << 25) | b | a | (f3 << 12) | ((imm & 32'h1f) << 7) | 32'h23;
    end else if (o <= 32) begin
      bad = (s < -4096) || (s > 4094) || (s % 2 != 0);
      f3 = 32'(F3BR[o - 27]);
      w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | b | a | (f3 << 12)
        | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
    end else if (o == 33) begin
      bad = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
        | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hff) << 12) | d | 32'h6f;
    end else if (o <= 36) begin
      bad = (imm & 32'hfff) != 32'd0;
      w = (imm & 32'hffff_f000) | d | ((o == 35) ? 32'h37 : 32'h17);
    end else begin
      bad = 1'b1;
    end
    e.inst = bad ? 32'h0000_0013 : w;
    e.err  = bad;
    return e;
  endfunction

  // Output-side checker: the queue holds every accepted-but-not-yet-transferred word.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_enc = 0;
      m_err = 0;
    end else begin
      chk("enc_count", 32'(enc_count), 32'(m_enc));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("in_ready", 32'(in_ready), 32'(!(q.size() >= 2 && !out_ready)));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_inst", out_inst, q[0].inst);
          chk("out_err", 32'(out_err), 32'(q[0].err));
          if (out_ready) begin
            m_enc = (m_enc + 1) % 65536;
            if (q[0].err && m_err < 255) m_err++;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_enc(in_op, in_rd, in_rs1, in_rs2, in_imm));
    end
  end

  function automatic logic [31:0] gen_imm();
    case ($urandom_range(0, 6))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       return 32'(BND[$urandom_range(0, 15)]);
      3:       return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      4:       return $urandom & 32'hffff_f000;
      5:       return 32'($urandom_range(0, 31));
      default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit got;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!got) chk("accept timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [5:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_inst, input logic exp_err);
    exp_t m;
    m = ref_enc(op, rd, rs1, rs2, imm);
    chk({name, " model inst"}, m.inst, exp_inst);
    chk({name, " model err"}, 32'(m.err), 32'(exp_err));
    send(op, rd, rs1, rs2, imm);
    @(negedge clk);
    chk({name, " out_valid early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({name, " out_valid"}, 32'(out_valid), 32'd1);
    chk({name, " inst"}, out_inst, exp_inst);
    chk({name, " err"}, 32'(out_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int    idx;
    bit    acc;
    #1 rst_n = 1'b0;
    #2;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_inst", out_inst, 32'h0000_0013);
    chk("reset out_err", 32'(out_err), 32'd0);
    chk("reset enc_count", 32'(enc_count), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    directed("ADDI",  6'd10, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 1'b0);
    directed("ADD",   6'd0,  5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3, 1'b0);
    directed("SW",    6'd26, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423, 1'b0);
    directed("BEQ",   6'd27, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_8463, 1'b0);
    directed("SRAI",  6'd16, 5'd1, 5'd1, 5'd0, 32'd3,          32'h4030_D093, 1'b0);
    directed("LUI",   6'd35, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 1'b0);
    directed("ADDI2048", 6'd10, 5'd1, 5'd0, 5'd0, 32'd2048,    32'h0000_0013, 1'b1);
    directed("BEQodd",   6'd27, 5'd0, 5'd1, 5'd2, 32'd3,       32'h0000_0013, 1'b1);
    directed("op40",     6'd40, 5'd1, 5'd1, 5'd1, 32'd0,       32'h0000_0013, 1'b1);
    chk("directed err_count", 32'(err_count), 32'd3);
    chk("directed enc_count", 32'(enc_count), 32'd9);

    // Backpressure: four bundles offered back to back with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_op = 6'd10; in_rd = 5'(idx + 1); in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 32'(idx + 1);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp accepts while stalled", 32'(idx), 32'd2);
    chk("bp in_ready low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      in_op = 6'd10; in_rd = 5'(idx + 1); in_rs1 = 5'd2; in_rs2 = 5'd0; in_imm = 32'(idx + 1);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    drain();
    chk("bp enc_count", 32'(enc_count), 32'd4);

    // Asynchronous reset with two bundles in flight.
    out_ready = 1'b0;
    send(6'd0, 5'd7, 5'd1, 5'd2, 32'd0);
    send(6'd10, 5'd8, 5'd1, 5'd0, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_inst", out_inst, 32'h0000_0013);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    chk("async rst enc_count", 32'(enc_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post-reset out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Random traffic with random consumer stalls.
    acc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc) begin
        if ($urandom_range(0, 4) != 0) begin
          in_op  = 6'($urandom_range(0, 39));
          in_rd  = 5'($urandom_range(0, 31));
          in_rs1 = 5'($urandom_range(0, 31));
          in_rs2 = 5'($urandom_range(0, 31));
          in_imm = gen_imm();
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
    end
    drain();
    @(negedge clk);
    chk("final enc_count", 32'(enc_count), 32'(m_enc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
